// File: rtl/id_issue_hazard_ctrl.sv
// Decode-to-execute issue controller: load-use/branch hazard stalls, bubbles and taken-branch squash.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module id_issue_hazard_ctrl #(
    parameter int MAX_STALL = 2,
    parameter int REG_W     = 5
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             id_valid_in,
    input  logic [REG_W-1:0] id_rs_in,
    input  logic [REG_W-1:0] id_rt_in,
    input  logic             id_uses_rs_in,
    input  logic             id_uses_rt_in,
    input  logic [REG_W-1:0] id_dest_in,
    input  logic             id_reg_write_in,
    input  logic             id_mem_read_in,
    input  logic             id_is_branch_in,
    input  logic             id_branch_taken_in,
    output logic             pc_write_out,
    output logic             if_id_write_out,
    output logic             if_id_flush_out,
    output logic             id_ex_bubble_out,
    output logic             stall_out,
    output logic             hazard_err_out,
    output logic [31:0]      stall_count_out,
    output logic [31:0]      flush_count_out
);

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    typedef enum logic {RUN, STALL} state_t;

    slot_t      ex_slot, mem_slot, id_slot;
    state_t     state;
    logic [2:0] run_cnt, run_next;
    logic       ex_dep, mem_dep, hazard, issue;

    // Register $0 never carries a dependency, and an unused operand field is don't-care.
    function automatic logic dep_match(input slot_t s, input logic [REG_W-1:0] r, input logic uses);
        return uses && s.reg_write && (s.dest == r) && (r != '0);
    endfunction

    assign ex_dep  = dep_match(ex_slot, id_rs_in, id_uses_rs_in)
                   | dep_match(ex_slot, id_rt_in, id_uses_rt_in);
    assign mem_dep = dep_match(mem_slot, id_rs_in, id_uses_rs_in)
                   | dep_match(mem_slot, id_rt_in, id_uses_rt_in);

    assign hazard = id_valid_in & ((ex_slot.mem_read & ex_dep)
                                 | (id_is_branch_in & ex_dep)
                                 | (id_is_branch_in & mem_slot.mem_read & mem_dep));

    assign issue            = id_valid_in & ~hazard;
    assign stall_out        = hazard;
    assign pc_write_out     = ~hazard;
    assign if_id_write_out  = ~hazard;
    assign id_ex_bubble_out = hazard | ~id_valid_in;
    assign if_id_flush_out  = issue & id_is_branch_in & id_branch_taken_in;

    assign id_slot = issue ? slot_t'{dest: id_dest_in, reg_write: id_reg_write_in, mem_read: id_mem_read_in}
                           : slot_t'('0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else begin
            mem_slot <= ex_slot;
            ex_slot  <= id_slot;
        end
    end

    // Length of the stall run including the current cycle, saturating at 7.
    assign run_next = (state == RUN) ? 3'd1 : ((run_cnt == 3'd7) ? 3'd7 : run_cnt + 3'd1);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state          <= RUN;
            run_cnt        <= '0;
            hazard_err_out <= 1'b0;
        end else if (hazard) begin
            state   <= STALL;
            run_cnt <= run_next;
            if (int'(run_next) > MAX_STALL)
                hazard_err_out <= 1'b1;
        end else begin
            state   <= RUN;
            run_cnt <= '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_out)       stall_cnt <= stall_cnt + 32'd1;
            if (if_id_flush_out) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_count_out = stall_cnt;
    assign flush_count_out = flush_cnt;
`else
    assign stall_count_out = '0;
    assign flush_count_out = '0;
`endif

endmodule

// File: tb/tb_id_issue_hazard_ctrl.sv
// Directed-vector bench for id_issue_hazard_ctrl; a second instance with MAX_STALL = 1 exercises the sticky error flag.
module tb_id_issue_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_is_branch, id_taken;
    logic [4:0] id_rs, id_rt, id_dest;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, stall, hazard_err;
    logic [31:0] stall_count, flush_count;
    logic        l_pc_write, l_if_id_write, l_if_id_flush, l_id_ex_bubble, l_stall, l_hazard_err;
    logic [31:0] l_stall_count, l_flush_count;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALLS  = 32'd4;
    localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    always #5 clk = ~clk;

    id_issue_hazard_ctrl #(.MAX_STALL(2), .REG_W(5)) dut (
        .clk(clk), .reset_in(reset_in),
        .id_valid_in(id_valid), .id_rs_in(id_rs), .id_rt_in(id_rt),
        .id_uses_rs_in(id_uses_rs), .id_uses_rt_in(id_uses_rt), .id_dest_in(id_dest),
        .id_reg_write_in(id_reg_write), .id_mem_read_in(id_mem_read),
        .id_is_branch_in(id_is_branch), .id_branch_taken_in(id_taken),
        .pc_write_out(pc_write), .if_id_write_out(if_id_write), .if_id_flush_out(if_id_flush),
        .id_ex_bubble_out(id_ex_bubble), .stall_out(stall), .hazard_err_out(hazard_err),
        .stall_count_out(stall_count), .flush_count_out(flush_count)
    );

    id_issue_hazard_ctrl #(.MAX_STALL(1), .REG_W(5)) u_lim (
        .clk(clk), .reset_in(reset_in),
        .id_valid_in(id_valid), .id_rs_in(id_rs), .id_rt_in(id_rt),
        .id_uses_rs_in(id_uses_rs), .id_uses_rt_in(id_uses_rt), .id_dest_in(id_dest),
        .id_reg_write_in(id_reg_write), .id_mem_read_in(id_mem_read),
        .id_is_branch_in(id_is_branch), .id_branch_taken_in(id_taken),
        .pc_write_out(l_pc_write), .if_id_write_out(l_if_id_write), .if_id_flush_out(l_if_id_flush),
        .id_ex_bubble_out(l_id_ex_bubble), .stall_out(l_stall), .hazard_err_out(l_hazard_err),
        .stall_count_out(l_stall_count), .flush_count_out(l_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Presents one ID-stage instruction for a full cycle and returns at the falling edge.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic mr, input logic br, input logic tk);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr; id_is_branch = br; id_taken = tk;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_in = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_is_branch = 1'b0; id_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_in = 1'b1;
        @(negedge clk);
        check("rst_pc_write", pc_write, 1);
        check("rst_if_id_write", if_id_write, 1);
        check("rst_flush", if_id_flush, 0);
        check("rst_bubble", id_ex_bubble, 1);
        check("rst_stall", stall, 0);
        check("rst_err", hazard_err, 0);
        check("rst_stall_cnt", stall_count, 0);
        check("rst_flush_cnt", flush_count, 0);

        // lw $8 ; add $10,$8,$9 -> one load-use stall
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
        check("s1_lw_stall", stall, 0);
        check("s1_lw_bubble", id_ex_bubble, 0);
        drive(1, 8, 9, 1, 1, 10, 1, 0, 0, 0);
        check("s1_use_stall", stall, 1);
        check("s1_use_pc_write", pc_write, 0);
        check("s1_use_if_id_write", if_id_write, 0);
        check("s1_use_bubble", id_ex_bubble, 1);
        drive(1, 8, 9, 1, 1, 10, 1, 0, 0, 0);
        check("s1_issue_stall", stall, 0);
        check("s1_issue_pc_write", pc_write, 1);
        check("s1_issue_bubble", id_ex_bubble, 0);
        idle();
        check("s1_idle_bubble", id_ex_bubble, 1);
        check("s1_idle_stall", stall, 0);
        idle();

        // lw $8 ; beq $9,$8 (not taken) -> exactly two stalls
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
        check("s2_lw_stall", stall, 0);
        drive(1, 9, 8, 1, 1, 0, 0, 0, 1, 0);
        check("s2_stall1", stall, 1);
        check("s2_stall1_flush", if_id_flush, 0);
        drive(1, 9, 8, 1, 1, 0, 0, 0, 1, 0);
        check("s2_stall2", stall, 1);
        check("s2_stall2_lim_err", l_hazard_err, 0);
        drive(1, 9, 8, 1, 1, 0, 0, 0, 1, 0);
        check("s2_issue_stall", stall, 0);
        check("s2_issue_flush", if_id_flush, 0);
        check("s2_err", hazard_err, 0);
        check("s2_lim_err_set", l_hazard_err, 1);
        idle();
        idle();

        // add $5 ; beq $5,$6 taken -> one stall, no flush while stalled, then one flush
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        check("s3_add_stall", stall, 0);
        drive(1, 5, 6, 1, 1, 0, 0, 0, 1, 1);
        check("s3_stall", stall, 1);
        check("s3_stall_flush", if_id_flush, 0);
        drive(1, 5, 6, 1, 1, 0, 0, 0, 1, 1);
        check("s3_issue_stall", stall, 0);
        check("s3_issue_flush", if_id_flush, 1);
        check("s3_issue_pc_write", pc_write, 1);
        idle();
        check("s3_flush_drop", if_id_flush, 0);
        check("s3_stall_count", stall_count, EXP_STALLS);
        check("s3_flush_count", flush_count, EXP_FLUSHES);
        check("s3_err", hazard_err, 0);
        check("s3_lim_err_sticky", l_hazard_err, 1);
        idle();

        // Non-hazards: $0 producer, unused rt, invalid ID, ALU producer feeding ALU
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(1, 0, 3, 1, 1, 2, 0, 0, 0, 0);
        check("s4_zero_dest", stall, 0);
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        drive(1, 3, 7, 1, 0, 2, 0, 0, 0, 0);
        check("s4_rt_unused", stall, 0);
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        drive(0, 7, 7, 1, 1, 2, 0, 0, 0, 0);
        check("s4_invalid", stall, 0);
        check("s4_invalid_bubble", id_ex_bubble, 1);
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        drive(1, 4, 3, 1, 1, 2, 0, 0, 0, 0);
        check("s4_alu_fwd", stall, 0);

        // rs = rt = loaded register -> single stall cycle
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        drive(1, 7, 7, 1, 1, 2, 0, 0, 0, 0);
        check("s4_dual_stall", stall, 1);
        drive(1, 7, 7, 1, 1, 2, 0, 0, 0, 0);
        check("s4_dual_issue", stall, 0);
        idle();

        // Reset asserted mid-stall clears scoreboard and sticky flag at once
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        drive(1, 9, 0, 1, 0, 2, 1, 0, 0, 0);
        check("s5_pre_stall", stall, 1);
        #1 reset_in = 1'b0;
        #1;
        check("s5_rst_stall", stall, 0);
        check("s5_rst_pc_write", pc_write, 1);
        check("s5_rst_lim_err", l_hazard_err, 0);
        check("s5_rst_stall_cnt", stall_count, 0);
        check("s5_rst_flush_cnt", flush_count, 0);
        @(posedge clk);
        #1 reset_in = 1'b1;
        idle();
        check("s5_post_lim_err", l_hazard_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
